// File: rtl/micro_pkg.sv
// Shared opcode and T-state definitions for the micro_sequencer.
// Optional single-step support is enabled by the SINGLE_STEP_EN macro.
package micro_pkg;

    localparam int OPW = 4;
    localparam int TW  = 3;

    localparam logic [OPW-1:0] OP_LDA = 4'h0;
    localparam logic [OPW-1:0] OP_ADD = 4'h1;
    localparam logic [OPW-1:0] OP_SUB = 4'h2;
    localparam logic [OPW-1:0] OP_MVC = 4'h3;
    localparam logic [OPW-1:0] OP_MVD = 4'h4;
    localparam logic [OPW-1:0] OP_OUT = 4'hE;
    localparam logic [OPW-1:0] OP_HLT = 4'hF;

    typedef enum logic [TW-1:0] {
        T_WAIT = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        T5     = 3'd5,
        T6     = 3'd6,
        T_HALT = 3'd7
    } t_state_e;

    // Opcodes that run the full six T-states.
    function automatic logic is_long_op(logic [OPW-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/t_state_counter.sv
// T-state register and next-state logic for micro_sequencer.
// SINGLE_STEP_EN adds the step input and the WAIT state between instructions.
module t_state_counter
    import micro_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
`ifdef SINGLE_STEP_EN
    input  logic          step_i,
`endif
    input  logic          short_i,
    input  logic          halt_i,
    output logic [TW-1:0] state_o
);

    t_state_e state_q;
    t_state_e state_d;
    t_state_e done_state;

    always_comb begin
`ifdef SINGLE_STEP_EN
        done_state = T_WAIT;
`else
        done_state = T1;
`endif
        state_d = state_q;
        case (state_q)
            T1:     state_d = T2;
            T2:     state_d = T3;
            T3:     state_d = T4;
            T4: begin
                if (halt_i) begin
                    state_d = T_HALT;
                end else if (short_i) begin
                    state_d = done_state;
                end else begin
                    state_d = T5;
                end
            end
            T5:     state_d = T6;
            T6:     state_d = done_state;
            // Only clr leaves HALT; the gated clock normally stops here anyway.
            T_HALT: state_d = T_HALT;
`ifdef SINGLE_STEP_EN
            T_WAIT: state_d = step_i ? T1 : T_WAIT;
`else
            T_WAIT: state_d = T1;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed T-state sequencer driving every datapath strobe of the 8-bit core.
// Define SINGLE_STEP_EN to add the step input and the WAIT state.
module micro_sequencer
    import micro_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
`ifdef SINGLE_STEP_EN
    input  logic           step,
`endif
    input  logic [OPW-1:0] op_code,
    output logic           inc,
    output logic           pc_out_en,
    output logic           low_ld_mar,
    output logic           low_mem_out_en,
    output logic           low_ld_ir,
    output logic           low_ir_out_en,
    output logic           low_ld_acc,
    output logic           acc_out_en,
    output logic           sub_add,
    output logic           subadd_out_en,
    output logic           low_ld_b_reg,
    output logic           low_ld_c,
    output logic           low_ld_d,
    output logic           low_ld_out_reg,
    output logic           low_halt,
    output logic [TW-1:0]  t_state,
    output logic           instr_done
);

    logic [TW-1:0] state_raw;
    t_state_e      state;
    logic          long_op;
    logic          halt_op;

    assign long_op = is_long_op(op_code);
    assign halt_op = (op_code == OP_HLT);
    assign state   = t_state_e'(state_raw);

    t_state_counter u_counter (
        .clk     (clk),
        .clr     (clr),
`ifdef SINGLE_STEP_EN
        .step_i  (step),
`endif
        .short_i (~long_op),
        .halt_i  (halt_op),
        .state_o (state_raw)
    );

    always_comb begin
        inc            = 1'b0;
        pc_out_en      = 1'b0;
        low_ld_mar     = 1'b1;
        low_mem_out_en = 1'b1;
        low_ld_ir      = 1'b1;
        low_ir_out_en  = 1'b1;
        low_ld_acc     = 1'b1;
        acc_out_en     = 1'b0;
        sub_add        = 1'b0;
        subadd_out_en  = 1'b0;
        low_ld_b_reg   = 1'b1;
        low_ld_c       = 1'b1;
        low_ld_d       = 1'b1;
        low_ld_out_reg = 1'b1;
        low_halt       = 1'b1;
        instr_done     = 1'b0;
        t_state        = state_raw;
        // clr masks the decode combinationally so a pending load never fires.
        if (clr) begin
            t_state = T1;
        end else begin
            case (state)
                T1: begin
                    pc_out_en  = 1'b1;
                    low_ld_mar = 1'b0;
                end
                T2: inc = 1'b1;
                T3: begin
                    low_mem_out_en = 1'b0;
                    low_ld_ir      = 1'b0;
                end
                T4: begin
                    instr_done = ~long_op;
                    if (long_op) begin
                        low_ir_out_en = 1'b0;
                        low_ld_mar    = 1'b0;
                    end else if (op_code == OP_MVC) begin
                        acc_out_en = 1'b1;
                        low_ld_c   = 1'b0;
                    end else if (op_code == OP_MVD) begin
                        acc_out_en = 1'b1;
                        low_ld_d   = 1'b0;
                    end else if (op_code == OP_OUT) begin
                        acc_out_en     = 1'b1;
                        low_ld_out_reg = 1'b0;
                    end
                end
                T5: begin
                    if (long_op) begin
                        low_mem_out_en = 1'b0;
                        sub_add        = (op_code == OP_SUB);
                        if (op_code == OP_LDA) begin
                            low_ld_acc = 1'b0;
                        end else begin
                            low_ld_b_reg = 1'b0;
                        end
                    end
                end
                T6: begin
                    instr_done = 1'b1;
                    if ((op_code == OP_ADD) || (op_code == OP_SUB)) begin
                        subadd_out_en = 1'b1;
                        low_ld_acc    = 1'b0;
                        sub_add       = (op_code == OP_SUB);
                    end
                end
                T_HALT: low_halt = 1'b0;
                T_WAIT: ;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios then random opcodes/clr/step
// compared against an instruction-level model.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic       step;
    logic [3:0] op_code;
    logic       inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir, low_ir_out_en;
    logic       low_ld_acc, acc_out_en, sub_add, subadd_out_en, low_ld_b_reg, low_ld_c;
    logic       low_ld_d, low_ld_out_reg, low_halt, instr_done;
    logic [2:0] t_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_no = 0;
    int m_t;        // model phase: 1..6 T-state, 7 halt, 0 wait

    typedef struct packed {
        logic inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir, low_ir_out_en;
        logic low_ld_acc, acc_out_en, sub_add, subadd_out_en, low_ld_b_reg, low_ld_c;
        logic low_ld_d, low_ld_out_reg, low_halt;
    } ctl_t;

`ifdef SINGLE_STEP_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk            (clk),
        .clr            (clr),
`ifdef SINGLE_STEP_EN
        .step           (step),
`endif
        .op_code        (op_code),
        .inc            (inc),
        .pc_out_en      (pc_out_en),
        .low_ld_mar     (low_ld_mar),
        .low_mem_out_en (low_mem_out_en),
        .low_ld_ir      (low_ld_ir),
        .low_ir_out_en  (low_ir_out_en),
        .low_ld_acc     (low_ld_acc),
        .acc_out_en     (acc_out_en),
        .sub_add        (sub_add),
        .subadd_out_en  (subadd_out_en),
        .low_ld_b_reg   (low_ld_b_reg),
        .low_ld_c       (low_ld_c),
        .low_ld_d       (low_ld_d),
        .low_ld_out_reg (low_ld_out_reg),
        .low_halt       (low_halt),
        .t_state        (t_state),
        .instr_done     (instr_done)
    );

    function automatic int instr_len(logic [3:0] op);
        return (op <= 4'h2) ? 6 : 4;
    endfunction

    function automatic ctl_t idle_ctl();
        ctl_t c;
        c = '0;
        c.low_ld_mar = 1; c.low_mem_out_en = 1; c.low_ld_ir = 1; c.low_ir_out_en = 1;
        c.low_ld_acc = 1; c.low_ld_b_reg = 1; c.low_ld_c = 1; c.low_ld_d = 1;
        c.low_ld_out_reg = 1; c.low_halt = 1;
        return c;
    endfunction

    // Expected strobes for a given phase/opcode, straight from the microcode table.
    function automatic ctl_t exp_ctl(int t, logic [3:0] op, logic c_clr);
        ctl_t c;
        c = idle_ctl();
        if (c_clr) return c;
        if (t == 1) begin c.pc_out_en = 1; c.low_ld_mar = 0; end
        if (t == 2) c.inc = 1;
        if (t == 3) begin c.low_mem_out_en = 0; c.low_ld_ir = 0; end
        if (t == 4) begin
            if (instr_len(op) == 6) begin c.low_ir_out_en = 0; c.low_ld_mar = 0; end
            if (op == 4'h3) begin c.acc_out_en = 1; c.low_ld_c = 0; end
            if (op == 4'h4) begin c.acc_out_en = 1; c.low_ld_d = 0; end
            if (op == 4'hE) begin c.acc_out_en = 1; c.low_ld_out_reg = 0; end
        end
        if (t == 5) begin
            c.low_mem_out_en = 0;
            if (op == 4'h0) c.low_ld_acc = 0;
            else c.low_ld_b_reg = 0;
            c.sub_add = (op == 4'h2);
        end
        if (t == 6 && op != 4'h0) begin
            c.subadd_out_en = 1; c.low_ld_acc = 0; c.sub_add = (op == 4'h2);
        end
        if (t == 7) c.low_halt = 0;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d t=%0d op=%h got %h want %h", tag, cyc_no, m_t, op_code,
                   obs, exp_v);
        end
    endtask

    // One clock: drive inputs, check outputs mid-low-phase, advance model on the edge.
    task automatic cyc(input logic c_clr, input logic [3:0] op, input logic st);
        ctl_t obs;
        ctl_t exp_c;
        int   exp_t;
        logic exp_done;
        @(negedge clk);
        clr = c_clr; op_code = op; step = st;
        #1;
        obs = '{inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir, low_ir_out_en,
                low_ld_acc, acc_out_en, sub_add, subadd_out_en, low_ld_b_reg, low_ld_c,
                low_ld_d, low_ld_out_reg, low_halt};
        exp_c    = exp_ctl(m_t, op, c_clr);
        exp_t    = c_clr ? 1 : m_t;
        exp_done = !c_clr && (m_t == 4 || m_t == 6) && (m_t == instr_len(op) || op == 4'hF);
        check("ctl", 32'(obs), 32'(exp_c));
        check("t_state", 32'(t_state), 32'(exp_t));
        check("instr_done", 32'(instr_done), 32'(exp_done));
        check("bus_excl", 32'($countones({pc_out_en, ~low_mem_out_en, ~low_ir_out_en,
                                          acc_out_en, subadd_out_en}) <= 1), 32'd1);
        @(posedge clk);
        cyc_no++;
        if (c_clr) m_t = 1;
        else if (m_t == 0) m_t = st ? 1 : 0;
        else if (m_t == 7) m_t = 7;
        else if (m_t == 4 && op == 4'hF) m_t = 7;
        else if (m_t == instr_len(op)) m_t = SS ? 0 : 1;
        else m_t = m_t + 1;
    endtask

    task automatic release_wait(input logic [3:0] op);
        if (SS) cyc(1'b0, op, 1'b1);
    endtask

    initial begin
        logic [3:0] rop;
        int         halt_cnt;
        logic       rclr;
        clr = 1'b1; op_code = 4'h0; step = 1'b0;
        m_t = 1;

        // Reset for two cycles, then ADD.
        cyc(1'b1, 4'h1, 1'b0);
        cyc(1'b1, 4'h1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'h1, 1'b0);
        release_wait(4'h1);
        // MVC, a short instruction.
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h3, 1'b0);
        release_wait(4'h3);
        // HLT: four T-states then HALT held for ten cycles, then clr.
        for (int i = 0; i < 14; i++) cyc(1'b0, 4'hF, 1'b0);
        check("halt_state", 32'(t_state), 32'd7);
        cyc(1'b1, 4'hF, 1'b0);
        // SUB with clr landing in T5.
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h2, 1'b0);
        check("sub_at_t5", 32'(m_t), 32'd5);
        cyc(1'b1, 4'h2, 1'b0);
        // OUT; with single-step the machine idles in WAIT until step.
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'hE, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'hE, 1'b0 | SS ? 1'b0 : 1'b0);
        release_wait(4'hE);

        // Randomized run: new opcode at T1, occasional clr, random step.
        cyc(1'b1, 4'h0, 1'b0);
        rop = 4'h0;
        halt_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (m_t == 1) rop = 4'($urandom_range(0, 15));
            halt_cnt = (m_t == 7) ? halt_cnt + 1 : 0;
            rclr = ($urandom_range(0, 39) == 0) || (halt_cnt > 3);
            cyc(rclr, rop, 1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
